// File: rtl/ring_counter_if.sv
// Output bundle of the ring counter: current one-hot state and its wrap flag.
// err only exists when RING_COUNTER_SELFCORRECT_EN is defined.
interface ring_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] count;
  logic             wrap;
`ifdef RING_COUNTER_SELFCORRECT_EN
  logic             err;
`endif

  modport master (
    output count,
    output wrap
`ifdef RING_COUNTER_SELFCORRECT_EN
    , output err
`endif
  );

  modport slave (
    input count,
    input wrap
`ifdef RING_COUNTER_SELFCORRECT_EN
    , input err
`endif
  );
endinterface

// File: rtl/ring_counter.sv
// Free-running one-hot ring counter for strobe/slot sequencing.
// Optional RING_COUNTER_SELFCORRECT_EN reloads INIT from any non-one-hot state and drives err.
module ring_counter #(
  parameter int unsigned          WIDTH    = 4,
  parameter logic [WIDTH-1:0]     INIT     = WIDTH'(1),
  parameter bit                   DIR_LEFT = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  ring_counter_if.master bus
);

  // State one rotation before returning to INIT, i.e. INIT rotated once the opposite way.
  localparam logic [WIDTH-1:0] LAST = DIR_LEFT ? {INIT[0], INIT[WIDTH-1:1]}
                                               : {INIT[WIDTH-2:0], INIT[WIDTH-1]};

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("ring_counter: WIDTH must be >= 2");
    end
    if ($countones(INIT) != 1) begin : g_bad_init
      $error("ring_counter: INIT must be one-hot");
    end
  endgenerate

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] rotated;

  always_comb begin
    rotated = '0;
    if (DIR_LEFT) begin
      rotated = {count_q[WIDTH-2:0], count_q[WIDTH-1]};
    end else begin
      rotated = {count_q[0], count_q[WIDTH-1:1]};
    end
  end

`ifdef RING_COUNTER_SELFCORRECT_EN
  logic illegal;

  always_comb begin
    illegal = !$onehot(count_q);
    count_d = illegal ? INIT : rotated;
  end

  assign bus.err = illegal;
`else
  always_comb begin
    count_d = rotated;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= INIT;
    end else begin
      count_q <= count_d;
    end
  end

  assign bus.count = count_q;
  assign bus.wrap  = (count_q == LAST);

endmodule

// File: tb/tb_ring_counter.sv
// Directed vector bench for ring_counter: default, right-rotating and 8-bit offset-INIT instances.
module tb_ring_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ring_counter_if #(.WIDTH(4)) bus0 ();
  ring_counter_if #(.WIDTH(4)) bus1 ();
  ring_counter_if #(.WIDTH(8)) bus2 ();

  ring_counter #(.WIDTH(4), .INIT(4'b0001), .DIR_LEFT(1'b1)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  ring_counter #(.WIDTH(4), .INIT(4'b0001), .DIR_LEFT(1'b0)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  ring_counter #(.WIDTH(8), .INIT(8'b0000_0100), .DIR_LEFT(1'b1)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  typedef struct {
    logic       rst;
    logic [3:0] c0;
    logic [3:0] c1;
    logic [7:0] c2;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic [3:0] c0,
                              input logic [3:0] c1, input logic [7:0] c2);
    vec_t v;
    v.rst = r;
    v.c0  = c0;
    v.c1  = c1;
    v.c2  = c2;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r);
    rst = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset, then free-run 14 cycles (d0 ends at 0100 for the mid-sequence reset).
    add(1, 4'b0001, 4'b0001, 8'h04);
    add(0, 4'b0010, 4'b1000, 8'h08);
    add(0, 4'b0100, 4'b0100, 8'h10);
    add(0, 4'b1000, 4'b0010, 8'h20);
    add(0, 4'b0001, 4'b0001, 8'h40);
    add(0, 4'b0010, 4'b1000, 8'h80);
    add(0, 4'b0100, 4'b0100, 8'h01);
    add(0, 4'b1000, 4'b0010, 8'h02);
    add(0, 4'b0001, 4'b0001, 8'h04);
    add(0, 4'b0010, 4'b1000, 8'h08);
    add(0, 4'b0100, 4'b0100, 8'h10);
    add(0, 4'b1000, 4'b0010, 8'h20);
    add(0, 4'b0001, 4'b0001, 8'h40);
    add(0, 4'b0010, 4'b1000, 8'h80);
    add(0, 4'b0100, 4'b0100, 8'h01);
    // Mid-sequence reset, then rotation resumes.
    add(1, 4'b0001, 4'b0001, 8'h04);
    add(0, 4'b0010, 4'b1000, 8'h08);
    // Reset held for five edges.
    for (int i = 0; i < 5; i++) add(1, 4'b0001, 4'b0001, 8'h04);
    add(0, 4'b0010, 4'b1000, 8'h08);
    add(0, 4'b0100, 4'b0100, 8'h10);
    add(0, 4'b1000, 4'b0010, 8'h20);
    add(0, 4'b0001, 4'b0001, 8'h40);
    add(0, 4'b0010, 4'b1000, 8'h80);
    add(0, 4'b0100, 4'b0100, 8'h01);
    add(0, 4'b1000, 4'b0010, 8'h02);
    add(0, 4'b0001, 4'b0001, 8'h04);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst);
      chk("count0", 32'(bus0.count), 32'(vecs[i].c0));
      chk("wrap0",  32'(bus0.wrap),  32'(vecs[i].c0 == 4'b1000));
      chk("count1", 32'(bus1.count), 32'(vecs[i].c1));
      chk("wrap1",  32'(bus1.wrap),  32'(vecs[i].c1 == 4'b0010));
      chk("count2", 32'(bus2.count), 32'(vecs[i].c2));
      chk("wrap2",  32'(bus2.wrap),  32'(vecs[i].c2 == 8'h02));
`ifdef RING_COUNTER_SELFCORRECT_EN
      chk("err0",   32'(bus0.err),   32'(0));
`endif
    end

    // Illegal two-hot state injected between edges.
    force dut0.count_q = 4'b0110;
    #1;
    chk("forced_count0", 32'(bus0.count), 32'(4'b0110));
    chk("forced_wrap0",  32'(bus0.wrap),  32'(0));
`ifdef RING_COUNTER_SELFCORRECT_EN
    chk("forced_err0",   32'(bus0.err),   32'(1));
`endif
    release dut0.count_q;
    step(1'b0);
`ifdef RING_COUNTER_SELFCORRECT_EN
    chk("recover_count0", 32'(bus0.count), 32'(4'b0001));
    chk("recover_err0",   32'(bus0.err),   32'(0));
    step(1'b0);
    chk("resume_count0",  32'(bus0.count), 32'(4'b0010));
`else
    chk("illegal_rot0",   32'(bus0.count), 32'(4'b1100));
    step(1'b0);
    chk("illegal_rot0b",  32'(bus0.count), 32'(4'b1001));
`endif
    step(1'b1);
    chk("final_reset0", 32'(bus0.count), 32'(4'b0001));
    chk("final_wrap0",  32'(bus0.wrap),  32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
